reg_dump_ctrl: RTL and testbench

REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

---
 rtl/reg_dump_ctrl.sv | 144 ++++++++++++++
 tb/tb_reg_dump_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_ctrl.sv
// ---------------------------------------------------------------------------
// reg_dump_ctrl
//
// Walks a range of register-file addresses (first..last inclusive, wrapping
// past the top address) and streams each register value out over a
// valid/ready interface, one word every two clocks at full throughput.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   start       request a dump, sampled only while idle
//   first_adds  first register address to dump
//   last_adds   last register address to dump (inclusive)
//   rd_adds     address to the register-file combinational read port
//   rd_data     register-file read data for rd_adds, same cycle
//   out_valid   out_data/out_adds/out_last hold a valid word
//   out_ready   downstream accepts the word when high with out_valid
//   out_data    dumped register value
//   out_adds    address of the dumped register
//   out_last    word is the final one of the dump
//   busy        high whenever the controller is not idle
//   done        one-cycle pulse after the final word is accepted
// ---------------------------------------------------------------------------
module reg_dump_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_adds,
    input  logic [ADDR_W-1:0] last_adds,
    output logic [ADDR_W-1:0] rd_adds,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_adds,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   cur_reg, cur_next;
    logic [ADDR_W-1:0]   stop_reg, stop_next;
    logic                valid_reg, valid_next;
    logic [DATA_W-1:0]   data_reg, data_next;
    logic [ADDR_W-1:0]   adds_reg, adds_next;
    logic                last_reg, last_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;

    // Next-state and next-output logic
    always_comb begin
        state_next = state_reg;
        cur_next   = cur_reg;
        stop_next  = stop_reg;
        valid_next = valid_reg;
        data_next  = data_reg;
        adds_next  = adds_reg;
        last_next  = last_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    cur_next   = first_adds;
                    stop_next  = last_adds;
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                // rd_adds is cur_reg, so rd_data already belongs to this word
                data_next  = rd_data;
                adds_next  = cur_reg;
                last_next  = (cur_reg == stop_reg);
                valid_next = 1'b1;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (valid_reg && out_ready) begin
                    valid_next = 1'b0;
                    if (last_reg) begin
                        state_next = ST_DONE;
                    end else begin
                        // natural wrap of the ADDR_W-bit counter handles first > last
                        cur_next   = cur_reg + ADDR_W'(1);
                        state_next = ST_READ;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // busy/done are registered decodes of the state being entered
        busy_next = (state_next != ST_IDLE);
        done_next = (state_next == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cur_reg   <= '0;
            stop_reg  <= '0;
            valid_reg <= 1'b0;
            data_reg  <= '0;
            adds_reg  <= '0;
            last_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cur_reg   <= cur_next;
            stop_reg  <= stop_next;
            valid_reg <= valid_next;
            data_reg  <= data_next;
            adds_reg  <= adds_next;
            last_reg  <= last_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign rd_adds   = cur_reg;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;
    assign out_adds  = adds_reg;
    assign out_last  = last_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg_dump_ctrl
//
// Directed bench for reg_dump_ctrl. A behavioural register file feeds
// rd_data; each dump request pushes its expected words to a scoreboard
// queue, and a negedge monitor pops and compares on every handshake.
// ---------------------------------------------------------------------------
module tb_reg_dump_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 1 << ADDR_W;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              l;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] first_adds;
    logic [ADDR_W-1:0] last_adds;
    logic [ADDR_W-1:0] rd_adds;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_adds;
    logic              out_last;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] regs [NREG];
    exp_t              sb_q [$];

    int total = 0;
    int bad   = 0;
    int done_cnt   = 0;
    int busy_cnt   = 0;
    int accept_cnt = 0;

    // previous-negedge snapshot for stall-stability checks
    logic              stall_prev = 1'b0;
    logic [DATA_W-1:0] data_prev;
    logic [ADDR_W-1:0] adds_prev;
    logic              last_prev;

    reg_dump_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_adds (first_adds),
        .last_adds  (last_adds),
        .rd_adds    (rd_adds),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_adds   (out_adds),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    assign rd_data = regs[rd_adds];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected words for a dump, wrapping through the top address
    task automatic push_range(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l);
        logic [ADDR_W-1:0] a;
        exp_t e;
        a = f;
        for (int n = 0; n < NREG; n++) begin
            e.a = a;
            e.d = regs[a];
            e.l = (a == l);
            sb_q.push_back(e);
            if (a == l) break;
            a = a + ADDR_W'(1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l);
        first_adds = f;
        last_adds  = l;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        first_adds = '0;
        last_adds  = '0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (done_cnt > d0) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_timeout"}, 64'(seen), 64'd1);
    endtask

    // Monitor: scoreboard pop on handshake, stability while stalled
    always @(negedge clk) begin
        if (rst) begin
            stall_prev <= 1'b0;
        end else begin
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (stall_prev) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data",  64'(out_data),  64'(data_prev));
                check("stall_adds",  64'(out_adds),  64'(adds_prev));
                check("stall_last",  64'(out_last),  64'(last_prev));
            end
            if (out_valid && out_ready) begin
                accept_cnt++;
                if (sb_q.size() == 0) begin
                    check("unexpected_word", 64'(out_adds), 64'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("word_adds", 64'(out_adds), 64'(e.a));
                    check("word_data", 64'(out_data), 64'(e.d));
                    check("word_last", 64'(out_last), 64'(e.l));
                    $display("word adds=%0d data=%08h last=%0b", out_adds, out_data, out_last);
                end
            end
            stall_prev <= out_valid && !out_ready;
            data_prev  <= out_data;
            adds_prev  <= out_adds;
            last_prev  <= out_last;
        end
    end

    initial begin
        int d0, a0;
        bit hit;

        for (int i = 0; i < NREG; i++) regs[i] = DATA_W'(i) * 32'h1111_1111;
        rst = 1'b1;
        start = 1'b0;
        first_adds = '0;
        last_adds = '0;
        out_ready = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_valid",  64'(out_valid), 64'd0);
        check("rst_last",   64'(out_last),  64'd0);
        check("rst_data",   64'(out_data),  64'd0);
        check("rst_adds",   64'(out_adds),  64'd0);
        check("rst_busy",   64'(busy),      64'd0);
        check("rst_done",   64'(done),      64'd0);
        check("rst_rdadds", 64'(rd_adds),   64'd0);
        rst = 1'b0;
        tick();

        // A: 0..3 at full throughput
        out_ready = 1'b1;
        busy_cnt = 0;
        d0 = done_cnt;
        a0 = accept_cnt;
        push_range(5'd0, 5'd3);
        pulse_start(5'd0, 5'd3);
        wait_done(50, "a");
        repeat (3) tick();
        check("a_busy_cycles", 64'(busy_cnt),          64'd9);
        check("a_done_pulses", 64'(done_cnt - d0),     64'd1);
        check("a_words",       64'(accept_cnt - a0),   64'd4);
        check("a_queue_empty", 64'(sb_q.size()),       64'd0);
        $display("dump 0..3 complete");

        // B: wrapping range 30..1
        a0 = accept_cnt;
        push_range(5'd30, 5'd1);
        pulse_start(5'd30, 5'd1);
        wait_done(50, "b");
        tick();
        check("b_words",       64'(accept_cnt - a0), 64'd4);
        check("b_queue_empty", 64'(sb_q.size()),     64'd0);
        $display("dump 30..1 complete");

        // C: single word with 5-cycle stall
        out_ready = 1'b0;
        a0 = accept_cnt;
        push_range(5'd7, 5'd7);
        pulse_start(5'd7, 5'd7);
        repeat (5) tick();
        check("c_valid_stalled", 64'(out_valid), 64'd1);
        check("c_data_stalled",  64'(out_data),  64'(regs[7]));
        check("c_last_stalled",  64'(out_last),  64'd1);
        out_ready = 1'b1;
        wait_done(20, "c");
        tick();
        check("c_words", 64'(accept_cnt - a0), 64'd1);
        $display("dump 7..7 complete");

        // D: start during SEND is ignored
        out_ready = 1'b0;
        a0 = accept_cnt;
        push_range(5'd0, 5'd3);
        pulse_start(5'd0, 5'd3);
        repeat (2) tick();
        check("d_in_send", 64'(out_valid), 64'd1);
        pulse_start(5'd10, 5'd12);
        out_ready = 1'b1;
        wait_done(50, "d");
        tick();
        check("d_words",       64'(accept_cnt - a0), 64'd4);
        check("d_queue_empty", 64'(sb_q.size()),     64'd0);
        $display("dump 0..3 with ignored restart complete");

        // E: reset while sending word at adds 2 of 0..31
        push_range(5'd0, 5'd31);
        pulse_start(5'd0, 5'd31);
        hit = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid && out_adds == 5'd2) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        check("e_reach_word2", 64'(hit), 64'd1);
        rst = 1'b1;
        out_ready = 1'b0;
        d0 = done_cnt;
        tick();
        check("e_rst_valid", 64'(out_valid), 64'd0);
        check("e_rst_busy",  64'(busy),      64'd0);
        sb_q.delete();
        rst = 1'b0;
        repeat (6) tick();
        check("e_no_done", 64'(done_cnt - d0), 64'd0);
        check("e_idle",    64'(busy),          64'd0);
        out_ready = 1'b1;
        a0 = accept_cnt;
        push_range(5'd5, 5'd5);
        pulse_start(5'd5, 5'd5);
        wait_done(20, "e");
        tick();
        check("e_words", 64'(accept_cnt - a0), 64'd1);
        $display("abort and redump 5..5 complete");

        // F: random backpressure over the full range
        a0 = accept_cnt;
        d0 = done_cnt;
        push_range(5'd0, 5'd31);
        pulse_start(5'd0, 5'd31);
        for (int c = 0; c < 2000; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (done_cnt > d0) break;
        end
        check("f_done",        64'(done_cnt - d0),   64'd1);
        check("f_words",       64'(accept_cnt - a0), 64'd32);
        check("f_queue_empty", 64'(sb_q.size()),     64'd0);
        $display("random backpressure dump 0..31 complete");

        out_ready = 1'b0;
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
